// File: rtl/sp_ram_arbiter_if.sv
// Bus bundle between two requesters, the arbiter and a shared single-port RAM.
// The arbiter takes the slave view; the requesters and RAM model take the master view.
interface sp_ram_arbiter_if #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned ADDR  = 2
);
  logic             a_req;
  logic             a_we;
  logic [ADDR-1:0]  a_addr;
  logic [WIDTH-1:0] a_wdata;
  logic             a_gnt;
  logic             a_rvalid;
  logic [WIDTH-1:0] a_rdata;

  logic             b_req;
  logic             b_we;
  logic [ADDR-1:0]  b_addr;
  logic [WIDTH-1:0] b_wdata;
  logic             b_gnt;
  logic             b_rvalid;
  logic [WIDTH-1:0] b_rdata;

  logic             ram_en;
  logic [ADDR-1:0]  ram_addr;
  logic [WIDTH-1:0] ram_din;
  logic [WIDTH-1:0] ram_dout;

  modport slave (
    input  a_req, a_we, a_addr, a_wdata,
    input  b_req, b_we, b_addr, b_wdata,
    input  ram_dout,
    output a_gnt, a_rvalid, a_rdata,
    output b_gnt, b_rvalid, b_rdata,
    output ram_en, ram_addr, ram_din
  );

  modport master (
    output a_req, a_we, a_addr, a_wdata,
    output b_req, b_we, b_addr, b_wdata,
    output ram_dout,
    input  a_gnt, a_rvalid, a_rdata,
    input  b_gnt, b_rvalid, b_rdata,
    input  ram_en, ram_addr, ram_din
  );
endinterface

// File: rtl/sp_ram_arbiter.sv
// Round-robin arbiter sharing one single-port RAM between requesters A and B,
// returning each read result to its issuer one cycle after the grant.
module sp_ram_arbiter #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned ADDR  = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  sp_ram_arbiter_if.slave bus
);

  typedef enum logic {ReqA, ReqB} req_e;

  req_e             rr_last_q, rr_last_d;
  logic             a_rvalid_q, a_rvalid_d;
  logic             b_rvalid_q, b_rvalid_d;
  logic             a_gnt, b_gnt;
  logic             ram_en;
  logic [ADDR-1:0]  ram_addr;
  logic [WIDTH-1:0] ram_din;

  // Grants are gated by rst_n so nothing reaches the RAM while reset is held.
  always_comb begin
    a_gnt      = rst_n & bus.a_req & (~bus.b_req | (rr_last_q == ReqB));
    b_gnt      = rst_n & bus.b_req & (~bus.a_req | (rr_last_q == ReqA));
    rr_last_d  = rr_last_q;
    if (a_gnt) begin
      rr_last_d = ReqA;
    end else if (b_gnt) begin
      rr_last_d = ReqB;
    end
    a_rvalid_d = a_gnt & ~bus.a_we;
    b_rvalid_d = b_gnt & ~bus.b_we;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_last_q  <= ReqB;
      a_rvalid_q <= 1'b0;
      b_rvalid_q <= 1'b0;
    end else begin
      rr_last_q  <= rr_last_d;
      a_rvalid_q <= a_rvalid_d;
      b_rvalid_q <= b_rvalid_d;
    end
  end

  // Without a grant the RAM sees an idle read of address 0, whose result is dropped.
  always_comb begin
    ram_en   = 1'b0;
    ram_addr = '0;
    ram_din  = '0;
    if (a_gnt) begin
      ram_en   = bus.a_we;
      ram_addr = bus.a_addr;
      ram_din  = bus.a_wdata;
    end else if (b_gnt) begin
      ram_en   = bus.b_we;
      ram_addr = bus.b_addr;
      ram_din  = bus.b_wdata;
    end
  end

  always_comb begin
    bus.a_gnt    = a_gnt;
    bus.b_gnt    = b_gnt;
    bus.a_rvalid = a_rvalid_q;
    bus.b_rvalid = b_rvalid_q;
    bus.a_rdata  = a_rvalid_q ? bus.ram_dout : '0;
    bus.b_rdata  = b_rvalid_q ? bus.ram_dout : '0;
    bus.ram_en   = ram_en;
    bus.ram_addr = ram_addr;
    bus.ram_din  = ram_din;
  end

endmodule
